// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: N-channel valid/ready bundle feeding one registered valid/ready output.
interface rr_mux_n_if #(
    parameter int WIDTH = 16,
    parameter int NCH = 4
);
    localparam int SELW = $clog2(NCH);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0] in_valid;
    logic [NCH-1:0] in_ready;
    logic force_en;
    logic [SELW-1:0] force_sel;
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0] out_sel;
    logic out_valid;
    logic out_ready;
    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input in_ready, out_data, out_sel, out_valid
    );
    modport slave (
        input in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_mux_n.sv
// rr_mux_n: registered N-channel mux with round-robin or forced channel select and back-pressure.
module rr_mux_n #(
    parameter int WIDTH = 16,
    parameter int NCH = 4
) (
    input logic clk,
    input logic rst_n,
    rr_mux_n_if.slave bus
);
    localparam int SELW = $clog2(NCH);
    logic [SELW-1:0] ptr, g, nxt;
    logic [SELW:0] s;
    logic [2*NCH-1:0] rot;
    logic [WIDTH-1:0] wd;
    logic gnt, load;
    always_comb begin
        load = !bus.out_valid || bus.out_ready;
        g = '0;
        gnt = 1'b0;
        s = '0;
        rot = {bus.in_valid, bus.in_valid} >> ptr;
        if (bus.force_en) begin
            for (int i = 0; i < NCH; i++)
                if (bus.force_sel == SELW'(i) && bus.in_valid[i]) begin
                    g = SELW'(i);
                    gnt = 1'b1;
                end
        end else begin
            // walk priority from farthest to nearest so the channel at ptr wins last
            for (int k = NCH - 1; k >= 0; k--)
                if (rot[k]) begin
                    s = {1'b0, ptr} + (SELW+1)'(k);
                    g = (s >= (SELW+1)'(NCH)) ? SELW'(s - (SELW+1)'(NCH)) : SELW'(s);
                    gnt = 1'b1;
                end
        end
        nxt = (g == SELW'(NCH - 1)) ? '0 : g + 1'b1;
        wd = '0;
        for (int i = 0; i < NCH; i++)
            if (g == SELW'(i)) wd = bus.in_data[i*WIDTH +: WIDTH];
    end
    assign bus.in_ready = (rst_n && load && gnt) ? NCH'(1) << g : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_sel <= '0;
            ptr <= '0;
        end else if (load) begin
            bus.out_valid <= gnt;
            if (gnt) begin
                bus.out_data <= wd;
                bus.out_sel <= g;
                if (!bus.force_en) ptr <= nxt;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed checks of rr_mux_n in a 4x16 build and a 3x8 build.
module tb_rr_mux_n;
    logic clk = 0;
    logic rst_n = 1;
    int checks = 0;
    int errors = 0;
    rr_mux_n_if #(.WIDTH(16), .NCH(4)) a_if ();
    rr_mux_n_if #(.WIDTH(8), .NCH(3)) b_if ();
    rr_mux_n #(.WIDTH(16), .NCH(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    rr_mux_n #(.WIDTH(8), .NCH(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic out_a(input string tag, input logic [15:0] d, input logic [1:0] sel);
        chk({tag, "_v"}, a_if.out_valid, 1);
        chk({tag, "_d"}, a_if.out_data, d);
        chk({tag, "_s"}, a_if.out_sel, sel);
    endtask
    initial begin
        a_if.in_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        a_if.in_valid = 4'b1111;
        a_if.force_en = 0;
        a_if.force_sel = 0;
        a_if.out_ready = 1;
        b_if.in_data = {8'h33, 8'h22, 8'h11};
        b_if.in_valid = 3'b000;
        b_if.force_en = 0;
        b_if.force_sel = 0;
        b_if.out_ready = 1;
        #2 rst_n = 0;
        #1;
        chk("rst_valid", a_if.out_valid, 0);
        chk("rst_ready", a_if.in_ready, 0);
        tick();
        rst_n = 1;
        a_if.in_valid = 4'b0000;
        #1;
        chk("idle_ready", a_if.in_ready, 0);
        tick();
        chk("idle_valid", a_if.out_valid, 0);
        a_if.in_valid = 4'b1111;
        #1;
        chk("rr_ready0", a_if.in_ready, 4'b0001);
        tick(); out_a("rr0", 16'hA000, 0);
        tick(); out_a("rr1", 16'hA001, 1);
        tick(); out_a("rr2", 16'hA002, 2);
        tick(); out_a("rr3", 16'hA003, 3);
        tick(); out_a("rr4", 16'hA000, 0);
        chk("rr_ptr", dut_a.ptr, 1);
        a_if.force_en = 1;
        a_if.force_sel = 2;
        #1;
        chk("fx_ready", a_if.in_ready, 4'b0100);
        tick(); out_a("fx0", 16'hA002, 2);
        tick(); out_a("fx1", 16'hA002, 2);
        chk("fx_ptr", dut_a.ptr, 1);
        a_if.in_valid = 4'b1011;
        #1;
        chk("fx_nogrant_ready", a_if.in_ready, 0);
        tick();
        chk("fx_nogrant_valid", a_if.out_valid, 0);
        a_if.force_en = 0;
        a_if.in_valid = 4'b1111;
        #1;
        chk("sw_ready", a_if.in_ready, 4'b0010);
        tick(); out_a("sw0", 16'hA001, 1);
        tick(); out_a("sw1", 16'hA002, 2);
        chk("sw_ptr", dut_a.ptr, 3);
        a_if.in_valid = 4'b0100;
        tick(); out_a("sp0", 16'hA002, 2);
        chk("sp_ptr", dut_a.ptr, 3);
        a_if.in_valid = 4'b1001;
        tick(); out_a("sp1", 16'hA003, 3);
        tick(); out_a("sp2", 16'hA000, 0);
        a_if.in_valid = 4'b1111;
        a_if.out_ready = 0;
        #1;
        chk("bp_ready", a_if.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            out_a("bp_hold", 16'hA000, 0);
            chk("bp_ready_hold", a_if.in_ready, 0);
        end
        a_if.out_ready = 1;
        #1;
        chk("bp_release_ready", a_if.in_ready, 4'b0010);
        tick(); out_a("bp_next", 16'hA001, 1);
        a_if.out_ready = 0;
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", a_if.out_valid, 0);
        chk("mid_rst_data", a_if.out_data, 0);
        chk("mid_rst_sel", a_if.out_sel, 0);
        chk("mid_rst_ready", a_if.in_ready, 0);
        tick();
        rst_n = 1;
        a_if.in_valid = 4'b0000;
        b_if.in_valid = 3'b111;
        b_if.force_en = 1;
        b_if.force_sel = 3;
        #1;
        chk("n3_sel3_ready", b_if.in_ready, 0);
        tick();
        chk("n3_sel3_valid", b_if.out_valid, 0);
        tick();
        chk("n3_sel3_valid2", b_if.out_valid, 0);
        b_if.force_sel = 1;
        #1;
        chk("n3_sel1_ready", b_if.in_ready, 3'b010);
        tick();
        chk("n3_sel1_data", b_if.out_data, 8'h22);
        chk("n3_sel1_sel", b_if.out_sel, 1);
        b_if.force_en = 0;
        tick();
        chk("n3_rr0", b_if.out_sel, 0);
        tick();
        chk("n3_rr1", b_if.out_sel, 1);
        tick();
        chk("n3_rr2", b_if.out_sel, 2);
        chk("n3_rr2_data", b_if.out_data, 8'h33);
        tick();
        chk("n3_wrap", b_if.out_sel, 0);
        chk("n3_wrap_data", b_if.out_data, 8'h11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
